// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler that shares one UART transmitter among NREQ byte requesters.
// Also owns the transmitter baud code, which only changes between frames.
`timescale 1ns/1ps

module uart_tx_arbiter #(
    parameter int NREQ         = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_enable,
    input  logic [2:0]              cfg_baud_select,
    input  logic [NREQ-1:0]         req,
    input  logic [8*NREQ-1:0]       req_data,
    output logic [NREQ-1:0]         ack,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    active,
    output logic                    timeout_err,
    output logic                    Tx_EN,
    output logic                    Tx_WR,
    output logic [7:0]              Tx_DATA,
    output logic [2:0]              baud_select,
    input  logic                    Tx_BUSY
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DRAIN
    } state_t;

    state_t          state;
    logic [IW-1:0]   last;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   win;
    logic            hit;
    logic [7:0]      win_data;
    logic            grant;
    logic            frame_next;

    // Search from last+1 upward with wrap, so last is considered last.
    always_comb begin
        win = last;
        hit = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!hit && req[(int'(last) + k) % NREQ]) begin
                hit = 1'b1;
                win = IW'((int'(last) + k) % NREQ);
            end
        end
    end

    assign win_data = req_data[{win, 3'b000} +: 8];
    assign grant    = (state == IDLE) && cfg_enable && hit && !Tx_BUSY;

    always_comb begin
        frame_next = 1'b0;
        unique case (state)
            IDLE:    frame_next = grant;
            WRITE:   frame_next = Tx_BUSY || (cnt != CNT_LAST);
            DRAIN:   frame_next = Tx_BUSY;
            default: frame_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            last        <= IW'(NREQ - 1);
            cnt         <= '0;
            ack         <= '0;
            grant_id    <= '0;
            active      <= 1'b0;
            timeout_err <= 1'b0;
            Tx_EN       <= 1'b0;
            Tx_WR       <= 1'b0;
            Tx_DATA     <= 8'h00;
            baud_select <= 3'b000;
        end else begin
            ack         <= '0;
            timeout_err <= 1'b0;
            active      <= frame_next;
            Tx_EN       <= cfg_enable | frame_next;
            unique case (state)
                IDLE: begin
                    baud_select <= cfg_baud_select;
                    if (grant) begin
                        Tx_DATA   <= win_data;
                        ack[win]  <= 1'b1;
                        grant_id  <= win;
                        last      <= win;
                        Tx_WR     <= 1'b1;
                        cnt       <= '0;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    if (Tx_BUSY) begin
                        Tx_WR <= 1'b0;
                        state <= DRAIN;
                    end else if (cnt == CNT_LAST) begin
                        // Transmitter never took the byte: drop it.
                        Tx_WR       <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (!Tx_BUSY) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter with directed scenarios.
// A frame-level reference model predicts grants, timeouts and baud updates.
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int BT   = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              cfg_enable = 1'b0;
    logic [2:0]        cfg_baud_select = 3'd0;
    logic [NREQ-1:0]   req = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   ack;
    logic [1:0]        grant_id;
    logic              active;
    logic              timeout_err;
    logic              Tx_EN;
    logic              Tx_WR;
    logic [7:0]        Tx_DATA;
    logic [2:0]        baud_select;
    logic              Tx_BUSY;

    logic              tx_auto = 1'b0;
    logic              tx_force = 1'b0;
    logic              tx_busy_q = 1'b0;
    int                tx_cnt = 0;
    int                busy_len = 10;
    logic [NREQ-1:0]   rereq = '0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int         id;
        int         cyc;
        logic [7:0] data;
    } exp_t;

    exp_t gq[$];
    int   tq[$];
    int   ack_ids[$];
    int   ack_cycs[$];
    int   to_cycs[$];
    int   wr_runs[$];
    int   wr_run = 0;

    int         cyc = 0;
    bit         m_in_frame = 0;
    bit         m_writing = 0;
    int         m_left = 0;
    int         m_last = NREQ - 1;
    int         m_w = 0;
    logic [2:0] exp_baud = 3'd0;
    int         exp_gid = 0;
    bit         exp_active = 0;
    bit         exp_wr = 0;
    bit         exp_en = 0;

    uart_tx_arbiter #(.NREQ(NREQ), .BUSY_TIMEOUT(BT)) dut (
        .clk(clk),
        .reset(reset),
        .cfg_enable(cfg_enable),
        .cfg_baud_select(cfg_baud_select),
        .req(req),
        .req_data(req_data),
        .ack(ack),
        .grant_id(grant_id),
        .active(active),
        .timeout_err(timeout_err),
        .Tx_EN(Tx_EN),
        .Tx_WR(Tx_WR),
        .Tx_DATA(Tx_DATA),
        .baud_select(baud_select),
        .Tx_BUSY(Tx_BUSY)
    );

    always #5 clk = ~clk;

    assign Tx_BUSY = tx_auto ? tx_busy_q : tx_force;

    // Transmitter: busy one cycle after a write strobe, for busy_len cycles.
    always @(posedge clk) begin
        if (tx_cnt > 0) begin
            tx_cnt = tx_cnt - 1;
            if (tx_cnt == 0) tx_busy_q <= 1'b0;
        end else if (tx_auto && Tx_WR && !tx_busy_q) begin
            tx_busy_q <= 1'b1;
            tx_cnt = busy_len;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++)
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        return last;
    endfunction

    // Frame-level model: one byte per grant, a write window of BT cycles,
    // then wait for the transmitter to go quiet.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_in_frame = 0;
            m_writing  = 0;
            m_left     = 0;
            m_last     = NREQ - 1;
            exp_baud   = 3'd0;
            exp_gid    = 0;
            exp_active = 0;
            exp_wr     = 0;
            exp_en     = 0;
            gq.delete();
            tq.delete();
        end else begin
            cyc++;
            if (!m_in_frame) begin
                exp_baud = cfg_baud_select;
                if (cfg_enable && req != 0 && !Tx_BUSY) begin
                    m_w = rr_pick(m_last, req);
                    gq.push_back('{id: m_w, cyc: cyc,
                                   data: req_data[8*m_w +: 8]});
                    m_last     = m_w;
                    exp_gid    = m_w;
                    m_in_frame = 1;
                    m_writing  = 1;
                    m_left     = BT;
                end
            end else if (m_writing) begin
                if (Tx_BUSY) begin
                    m_writing = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        tq.push_back(cyc);
                        m_writing  = 0;
                        m_in_frame = 0;
                    end
                end
            end else if (!Tx_BUSY) begin
                m_in_frame = 0;
            end
            exp_active = m_in_frame;
            exp_wr     = m_writing;
            exp_en     = cfg_enable || m_in_frame;
        end
    end

    // Monitor: pops expectations whenever the DUT acks or flags a timeout.
    always @(negedge clk) begin
        int   ai;
        exp_t e;
        if (reset) begin
            if (ack != 0) begin
                ai = -1;
                for (int i = 0; i < NREQ; i++) if (ack[i]) ai = i;
                chk("ack_onehot", 32'($onehot(ack)), 32'd1);
                if (gq.size() == 0) begin
                    chk("unexpected_ack", 32'(ack), 32'd0);
                end else begin
                    e = gq.pop_front();
                    chk("ack_vec", 32'(ack), 32'(1 << e.id));
                    chk("ack_cycle", 32'(cyc), 32'(e.cyc));
                    chk("tx_data", 32'(Tx_DATA), 32'(e.data));
                end
                ack_ids.push_back(ai);
                ack_cycs.push_back(cyc);
            end else if (gq.size() > 0 && gq[0].cyc <= cyc) begin
                e = gq.pop_front();
                chk("missing_ack", 32'(ack), 32'(1 << e.id));
            end
            if (timeout_err) begin
                if (tq.size() == 0) begin
                    chk("unexpected_timeout", 32'(timeout_err), 32'd0);
                end else begin
                    chk("timeout_cycle", 32'(cyc), 32'(tq.pop_front()));
                end
                to_cycs.push_back(cyc);
            end else if (tq.size() > 0 && tq[0] <= cyc) begin
                void'(tq.pop_front());
                chk("missing_timeout", 32'(timeout_err), 32'd1);
            end
            chk("active", 32'(active), 32'(exp_active));
            chk("tx_wr", 32'(Tx_WR), 32'(exp_wr));
            chk("tx_en", 32'(Tx_EN), 32'(exp_en));
            chk("baud", 32'(baud_select), 32'(exp_baud));
            chk("grant_id", 32'(grant_id), 32'(exp_gid));
            if (Tx_WR) begin
                wr_run++;
            end else if (wr_run > 0) begin
                wr_runs.push_back(wr_run);
                wr_run = 0;
            end
        end else begin
            wr_run = 0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (ack[i]) begin
                if (rereq[i]) req_data[8*i +: 8] = 8'($urandom);
                else req[i] = 1'b0;
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ack"}, 32'(ack), 32'd0);
        chk({tag, "_gid"}, 32'(grant_id), 32'd0);
        chk({tag, "_active"}, 32'(active), 32'd0);
        chk({tag, "_terr"}, 32'(timeout_err), 32'd0);
        chk({tag, "_txen"}, 32'(Tx_EN), 32'd0);
        chk({tag, "_txwr"}, 32'(Tx_WR), 32'd0);
        chk({tag, "_txdata"}, 32'(Tx_DATA), 32'd0);
        chk({tag, "_baud"}, 32'(baud_select), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_reset_vals("rst");
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while ((req != 0 || m_in_frame) && n < budget);
        chk({tag, "_done"}, 32'(req != 0 || m_in_frame), 32'd0);
    endtask

    task automatic wait_ack(input int budget, input string tag);
        int n0 = ack_ids.size();
        int n = 0;
        do begin
            tick();
            n++;
        end while (ack_ids.size() == n0 && n < budget);
        chk({tag, "_acked"}, 32'(ack_ids.size() > n0), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, t0, r0, a0;

        cfg_baud_select = 3'd3;
        cfg_enable      = 1'b1;
        tx_auto         = 1'b1;
        repeat (3) @(negedge clk);
        #1 check_reset_vals("init");
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Single request on requester 2.
        n0 = ack_ids.size();
        r0 = wr_runs.size();
        req_data[23:16] = 8'h94;
        req = 4'b0100;
        wait_done(100, "single");
        chk("single_count", 32'(ack_ids.size()), 32'(n0 + 1));
        if (ack_ids.size() > n0) chk("single_id", 32'(ack_ids[n0]), 32'd2);
        chk("single_gid", 32'(grant_id), 32'd2);
        chk("single_data", 32'(Tx_DATA), 32'h94);
        if (wr_runs.size() > r0) chk("single_wr_len", 32'(wr_runs[r0]), 32'd2);

        // All four from reset: order 0..3, one idle cycle between frames.
        do_reset();
        n0 = ack_ids.size();
        for (int i = 0; i < NREQ; i++) req_data[8*i +: 8] = 8'($urandom);
        req = 4'b1111;
        wait_done(200, "all4");
        chk("all4_count", 32'(ack_ids.size()), 32'(n0 + 4));
        for (int k = 0; k < 4 && n0 + k < ack_ids.size(); k++) begin
            chk("all4_order", 32'(ack_ids[n0 + k]), 32'(k));
            if (k > 0)
                chk("all4_gap", 32'(ack_cycs[n0 + k] - ack_cycs[n0 + k - 1]),
                    32'd13);
        end

        // Fairness between requesters 0 and 2.
        do_reset();
        n0 = ack_ids.size();
        rereq = 4'b0101;
        req   = 4'b0101;
        for (int c = 0; c < 300 && ack_ids.size() < n0 + 6; c++) tick();
        rereq = '0;
        wait_done(200, "fair");
        chk("fair_count", 32'(ack_ids.size() >= n0 + 6), 32'd1);
        for (int k = 0; k < 6 && n0 + k < ack_ids.size(); k++)
            chk("fair_order", 32'(ack_ids[n0 + k]), 32'((k % 2) * 2));

        // Busy timeout with the transmitter silent.
        do_reset();
        tx_auto  = 1'b0;
        tx_force = 1'b0;
        n0 = ack_ids.size();
        t0 = to_cycs.size();
        r0 = wr_runs.size();
        rereq = 4'b0001;
        req   = 4'b0001;
        wait_ack(10, "to_first");
        for (int c = 0; c < 60 && to_cycs.size() == t0; c++) tick();
        chk("to_seen", 32'(to_cycs.size() > t0), 32'd1);
        rereq = '0;
        wait_ack(10, "to_regrant");
        if (to_cycs.size() > t0 && ack_cycs.size() > n0 + 1) begin
            a0 = ack_cycs[n0];
            chk("to_latency", 32'(to_cycs[t0] - a0), 32'd16);
            chk("to_regrant", 32'(ack_cycs[n0 + 1] - to_cycs[t0]), 32'd1);
        end
        if (wr_runs.size() > r0) chk("to_wr_len", 32'(wr_runs[r0]), 32'd16);
        wait_done(60, "to");
        tx_auto = 1'b1;

        // Baud code frozen for the length of a frame.
        cfg_baud_select = 3'b111;
        repeat (3) tick();
        req = 4'b0010;
        wait_ack(10, "baud");
        cfg_baud_select = 3'b010;
        repeat (3) tick();
        chk("baud_frozen", 32'(baud_select), 32'd7);
        wait_done(60, "baud");
        chk("baud_at_idle", 32'(baud_select), 32'd7);
        tick();
        chk("baud_updated", 32'(baud_select), 32'd2);

        // Reset in the middle of a frame.
        req = 4'b1000;
        wait_ack(10, "midrst");
        repeat (3) tick();
        chk("midrst_active", 32'(active), 32'd1);
        do_reset();
        n0 = ack_ids.size();
        repeat (20) tick();
        chk("midrst_noack", 32'(ack_ids.size()), 32'(n0));

        // cfg_enable dropped during DRAIN: frame completes, no new grants.
        rereq = 4'b0001;
        req   = 4'b0001;
        wait_ack(30, "endrop");
        for (int c = 0; c < 10 && !Tx_BUSY; c++) tick();
        tick();
        cfg_enable = 1'b0;
        n0 = ack_ids.size();
        repeat (40) tick();
        chk("endrop_noack", 32'(ack_ids.size()), 32'(n0));
        chk("endrop_txen", 32'(Tx_EN), 32'd0);
        chk("endrop_active", 32'(active), 32'd0);
        chk("endrop_req", 32'(req), 32'd1);
        rereq = '0;
        cfg_enable = 1'b1;
        wait_done(100, "endrop");

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            tick();
            if ($urandom_range(0, 49) == 0)
                cfg_enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0)
                cfg_baud_select = 3'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                tx_auto  = ($urandom_range(0, 3) != 0);
                tx_force = 1'($urandom);
            end
            if ($urandom_range(0, 29) == 0)
                busy_len = $urandom_range(1, 12);
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 7) == 0) begin
                    req[i] = 1'b1;
                    req_data[8*i +: 8] = 8'($urandom);
                end else if (req[i] && $urandom_range(0, 63) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
        tx_auto    = 1'b1;
        cfg_enable = 1'b1;
        wait_done(3000, "rand");
        repeat (3) tick();
        chk("sb_grants_empty", 32'(gq.size()), 32'd0);
        chk("sb_timeouts_empty", 32'(tq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares a single UART transmitter among NREQ byte requesters. Sits between client logic and the transmitter's `Tx_EN`/`Tx_WR`/`Tx_DATA`/`baud_select`/`Tx_BUSY` interface. Also owns the transmitter baud configuration, updating it only between frames. One byte per grant; a new grant is issued only after the previous frame completes.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `BUSY_TIMEOUT`, 16: cycles to wait for `Tx_BUSY` to rise after `Tx_WR` before abandoning the byte.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cfg_enable`  in  1  allows new grants when high.
- `cfg_baud_select`  in  3  requested baud code; propagated only while in IDLE.
- `req`  in  NREQ  per-requester request; held high until `ack`.
- `req_data`  in  8*NREQ  packed bytes; requester i at [8i+7:8i]; held stable until `ack`.
- `ack`  out  NREQ  one-hot, one-cycle pulse: byte captured.
- `grant_id`  out  clog2(NREQ)  index of last granted requester.
- `active`  out  1  high in any state other than IDLE.
- `timeout_err`  out  1  one-cycle pulse on busy timeout.
- `Tx_EN`  out  1  transmitter enable.
- `Tx_WR`  out  1  transmitter write strobe.
- `Tx_DATA`  out  8  byte to transmitter.
- `baud_select`  out  3  transmitter baud code.
- `Tx_BUSY`  in  1  transmitter busy.

## Operation
- FSM states: IDLE, WRITE, DRAIN.
- IDLE:
  - `baud_select <= cfg_baud_select` every cycle.
  - If `cfg_enable & |req & !Tx_BUSY`, pick the winner by round-robin: search from `last+1` upward, wrap at NREQ-1, `last` checked last.
  - On a grant: `Tx_DATA <= req_data[winner]`, `ack[winner] <= 1`, `grant_id <= winner`, `last <= winner`, `Tx_WR <= 1`, clear timeout counter, go to WRITE.
- WRITE:
  - `Tx_WR` is held at 1.
  - If `Tx_BUSY`=1: `Tx_WR <= 0`, go to DRAIN.
  - Else, if the counter equals BUSY_TIMEOUT-1: `Tx_WR <= 0`, `timeout_err <= 1`, go to IDLE. The byte is dropped and `last` keeps the granted index.
  - Else: increment the counter.
- DRAIN:
  - If `Tx_BUSY`=0, go to IDLE.
- `Tx_EN` = `cfg_enable | active` (registered). Deasserting `cfg_enable` mid-frame completes the frame; no further grants follow.
- `baud_select` is frozen outside IDLE.
- Requests arriving while not in IDLE are not lost; they are arbitrated on return to IDLE.

## Timing
- Reset values: `ack`=0, `grant_id`=0, `active`=0, `timeout_err`=0, `Tx_EN`=0, `Tx_WR`=0, `Tx_DATA`=8'h00, `baud_select`=3'b000, `last`=NREQ-1 (requester 0 wins first), state=IDLE.
- Reset asserted mid-frame returns immediately to the reset values; the partially sent byte is not re-requested.
- All outputs are registered.
- Grant latency: `req` sampled at edge N → `ack`, `Tx_WR`, `Tx_DATA` valid after edge N.
- `ack` is high exactly one cycle. The requester may change `req`/`req_data` from the edge after `ack`.
- Back-to-back frames: DRAIN sees `Tx_BUSY`=0 at edge M → IDLE. Next `Tx_WR` rises after edge M+1. Minimum gap between frames is 1 idle cycle.
- Timeout: `Tx_WR` is high for exactly BUSY_TIMEOUT cycles before `timeout_err` pulses.
- `Tx_BUSY` high while in IDLE blocks grants and does not raise any error.
- A requester dropping `req` before `ack` is simply skipped.

## Test plan
- Single request: `req`=4'b0100, `req_data[23:16]`=8'h94.
  - Required: `ack`=4'b0100 for one cycle; `Tx_DATA`=8'h94; `Tx_WR` high until `Tx_BUSY` rises; `grant_id`=2.
- All four requesting from reset with a transmitter model (busy 10 cycles per frame).
  - Required: grant order 0,1,2,3; exactly 1 idle cycle between frames.
- Fairness: requesters 0 and 2 request continuously for 6 frames.
  - Required: order 0,2,0,2,0,2; requester 0 never granted twice in a row.
- Timeout: `Tx_BUSY` tied 0, `req`=4'b0001, BUSY_TIMEOUT=16.
  - Required: `Tx_WR` high 16 cycles, then one-cycle `timeout_err`, then return to IDLE.
  - Required: with `req` still high, a regrant occurs next cycle.
- Baud freeze: change `cfg_baud_select` from 3'b111 to 3'b010 mid-frame.
  - Required: `baud_select` stays 3'b111 until the cycle after return to IDLE.
- Reset mid-frame, plus `cfg_enable`=0 during DRAIN.
  - Reset: all outputs return to reset values asynchronously.
  - `cfg_enable` drop: the frame completes, then no grants while `req` stays high.
